// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared state type and sizing helpers for the iterative magnitude comparator
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

    function automatic int nchunk(input int n, input int w);
        return n / w;
    endfunction

    // Chunk index needs at least one bit even when the whole operand is a single chunk
    function automatic int idx_width(input int nchunks);
        return (nchunks > 1) ? $clog2(nchunks) : 1;
    endfunction

endpackage

// File: rtl/cmp_chunk.sv
// rtl/cmp_chunk.sv - combinational W-bit unsigned comparator
module cmp_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt,
    output logic         eq
);

    assign gt = (a > b);
    assign eq = (a == b);

endmodule

// File: rtl/mag_cmp_iter.sv
// rtl/mag_cmp_iter.sv - multi-cycle MSB-first chunked magnitude comparator with valid/ready ends
module mag_cmp_iter
    import cmp_pkg::*;
#(
    parameter int N         = 32,
    parameter int W         = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0]          num1,
    input  logic [N-1:0]          num2,
    input  logic                  signed_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  g,
    output logic                  e,
    output logic                  l,
    output logic [$clog2(N/W):0]  ncyc
);

    localparam int NCHUNK = nchunk(N, W);
    localparam int KW     = idx_width(NCHUNK);
    localparam int CW     = $clog2(NCHUNK) + 1;

    if ((W < 1) || (W > N) || ((N % W) != 0)) begin : g_param_err
        $error("mag_cmp_iter: N must be a multiple of W with 1 <= W <= N");
    end

    cmp_state_t      state_q, state_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic [KW-1:0]   k_q, k_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            g_q, g_d;
    logic            e_q, e_d;
    logic            l_q, l_d;

    logic [W-1:0]    a_chunk;
    logic [W-1:0]    b_chunk;
    logic            chunk_gt;
    logic            chunk_eq;
    logic            sflag;
    logic            capture;

    assign a_chunk = a_q[int'(k_q) * W +: W];
    assign b_chunk = b_q[int'(k_q) * W +: W];

    cmp_chunk #(.W(W)) u_chunk (
        .a  (a_chunk),
        .b  (b_chunk),
        .gt (chunk_gt),
        .eq (chunk_eq)
    );

    assign sflag = signed_mode & SIGNED_EN;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        g_d       = g_q;
        e_d       = e_q;
        l_d       = l_q;
        in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
        out_valid = (state_q == DONE);
        capture   = in_valid && in_ready;

        case (state_q)
            IDLE: begin
                if (capture) state_d = SCAN;
            end
            SCAN: begin
                cnt_d = cnt_q + CW'(1);
                if (!chunk_eq) begin
                    g_d     = chunk_gt;
                    e_d     = 1'b0;
                    l_d     = ~chunk_gt;
                    state_d = DONE;
                end else if (k_q == '0) begin
                    g_d     = 1'b0;
                    e_d     = 1'b1;
                    l_d     = 1'b0;
                    state_d = DONE;
                end else begin
                    k_d = k_q - KW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    g_d     = 1'b0;
                    e_d     = 1'b0;
                    l_d     = 1'b0;
                    state_d = in_valid ? SCAN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flipping the sign bit maps two's-complement order onto unsigned order
        if (capture) begin
            a_d        = num1;
            b_d        = num2;
            a_d[N-1]   = num1[N-1] ^ sflag;
            b_d[N-1]   = num2[N-1] ^ sflag;
            k_d        = KW'(NCHUNK - 1);
            cnt_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            g_q     <= 1'b0;
            e_q     <= 1'b0;
            l_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            g_q     <= g_d;
            e_q     <= e_d;
            l_q     <= l_d;
        end
    end

    assign g    = g_q;
    assign e    = e_q;
    assign l    = l_q;
    assign ncyc = cnt_q;

endmodule

// File: tb/tb_mag_cmp_iter.sv
// tb/tb_mag_cmp_iter.sv - self-checking bench for mag_cmp_iter across three N/W configurations
module tb_mag_cmp_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: signed/unsigned arithmetic compare; scan length from the highest differing bit
    function automatic void ref_cmp(input logic [63:0] a, input logic [63:0] b, input int n,
                                    input int w, input bit sm, output logic [2:0] gel, output int nc);
        longint    sa;
        longint    sb;
        logic [63:0] x;
        int        m;
        sa = longint'(a);
        sb = longint'(b);
        if (sm) begin
            if (a[n-1]) sa = sa - (longint'(1) << n);
            if (b[n-1]) sb = sb - (longint'(1) << n);
        end
        gel = (sa > sb) ? 3'b100 : ((sa == sb) ? 3'b010 : 3'b001);
        x = a ^ b;
        m = -1;
        for (int i = 0; i < n; i++) if (x[i]) m = i;
        nc = (m < 0) ? n / w : n / w - m / w;
    endfunction

    // Main DUT: N=32, W=8
    logic        rst_n, in_valid, in_ready, signed_mode, out_valid, out_ready, g, e, l;
    logic [31:0] num1, num2;
    logic [2:0]  ncyc;

    mag_cmp_iter #(.N(32), .W(8), .SIGNED_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .num1(num1), .num2(num2), .signed_mode(signed_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .g(g), .e(e), .l(l), .ncyc(ncyc)
    );

    task automatic send(input logic [31:0] a, input logic [31:0] b, input bit sm);
        int t;
        @(negedge clk);
        in_valid = 1'b1; num1 = a; num2 = b; signed_mode = sm;
        t = 0;
        while (!in_ready && t < 20) begin @(negedge clk); t++; end
        chk("send_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; num1 = $urandom; num2 = $urandom; signed_mode = 1'($urandom);
    endtask

    task automatic wait_result(input string name, input logic [2:0] exp_gel, input int exp_nc,
                               input int exp_lat, input int stall);
        int lat;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) chk({name, "_scan_gel_zero"}, {g, e, l}, 3'b000);
        end while (!out_valid && lat < 100);
        chk({name, "_out_valid"}, out_valid, 1);
        chk({name, "_gel"}, {g, e, l}, exp_gel);
        chk({name, "_ncyc"}, ncyc, exp_nc);
        chk({name, "_latency"}, lat, exp_lat);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({name, "_stall_gel"}, {g, e, l}, exp_gel);
            chk({name, "_stall_ncyc"}, ncyc, exp_nc);
            chk({name, "_stall_in_ready"}, in_ready, 0);
            chk({name, "_stall_out_valid"}, out_valid, 1);
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          sm;
        logic [2:0]  gel;
        int          nc;
        int          lat;
    } vec_t;

    vec_t tbl[9];

    // Two N=16 instances: W=1 and W=16, each with its own reset and random stream
    for (genvar gi = 0; gi < 2; gi++) begin : g_sub
        localparam int WS = (gi == 0) ? 1 : 16;
        localparam int NC = 16 / WS;
        logic        rst_s, iv, ir, sms, ov, orr, gs, es, ls;
        logic [15:0] n1, n2;
        logic [$clog2(NC):0] ncs;
        bit          done = 1'b0;

        mag_cmp_iter #(.N(16), .W(WS), .SIGNED_EN(1'b1)) u_dut (
            .clk(clk), .rst_n(rst_s), .in_valid(iv), .in_ready(ir),
            .num1(n1), .num2(n2), .signed_mode(sms),
            .out_valid(ov), .out_ready(orr),
            .g(gs), .e(es), .l(ls), .ncyc(ncs)
        );

        initial begin
            logic [2:0]  eg;
            int          en;
            int          t;
            logic [15:0] a, b;
            bit          sm;
            rst_s = 1'b0; iv = 1'b0; orr = 1'b0; n1 = '0; n2 = '0; sms = 1'b0;
            repeat (3) @(negedge clk);
            rst_s = 1'b1;
            for (int i = 0; i < 2001; i++) begin
                if (i == 0) begin
                    a = 16'h0001; b = 16'h0000; sm = 1'b0;
                    eg = 3'b100; en = (WS == 1) ? 16 : 1;
                end else begin
                    a = 16'($urandom);
                    case ($urandom_range(0, 3))
                        0:       b = a;
                        1:       b = a ^ (16'h1 << $urandom_range(0, 15));
                        default: b = 16'($urandom);
                    endcase
                    sm = 1'($urandom);
                    ref_cmp({48'h0, a}, {48'h0, b}, 16, WS, sm, eg, en);
                end
                @(negedge clk);
                iv = 1'b1; n1 = a; n2 = b; sms = sm;
                chk($sformatf("w%0d_in_ready", WS), ir, 1);
                @(posedge clk);
                #1;
                iv = 1'b0; n1 = 16'($urandom); n2 = 16'($urandom);
                t = 0;
                do begin @(negedge clk); t++; end while (!ov && t < 40);
                chk($sformatf("w%0d_out_valid", WS), ov, 1);
                chk($sformatf("w%0d_gel a=%h b=%h s=%0d", WS, a, b, sm), {gs, es, ls}, eg);
                chk($sformatf("w%0d_ncyc a=%h b=%h", WS, a, b), ncs, en);
                chk($sformatf("w%0d_latency", WS), t, 1 + en);
                @(negedge clk);
                orr = 1'b1;
                @(posedge clk);
                #1;
                orr = 1'b0;
            end
            done = 1'b1;
        end
    end

    initial begin
        logic [2:0]  eg;
        int          en;
        int          t;
        logic [31:0] a, b;
        bit          sm;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        num1 = '0; num2 = '0; signed_mode = 1'b0;

        tbl[0] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 3'b100, 1, 2};
        tbl[1] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3'b010, 4, 5};
        tbl[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'b001, 1, 2};
        tbl[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'b100, 1, 2};
        tbl[4] = '{32'h1234_5600, 32'h1234_5601, 1'b0, 3'b001, 4, 5};
        tbl[5] = '{32'h0000_0005, 32'h0000_0009, 1'b1, 3'b001, 4, 5};
        tbl[6] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'b001, 1, 2};
        tbl[7] = '{32'h0000_1000, 32'h0000_2000, 1'b0, 3'b001, 3, 4};
        tbl[8] = '{32'h0012_0000, 32'h0011_0000, 1'b1, 3'b100, 2, 3};

        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_gel", {g, e, l}, 3'b000);
        chk("rst_ncyc", ncyc, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);

        for (int i = 0; i < 9; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].sm);
            wait_result($sformatf("tbl%0d", i), tbl[i].gel, tbl[i].nc, tbl[i].lat, i % 3);
            release_out();
        end

        // Backpressure for 3 cycles, then accept the next pair in the same cycle the result leaves
        send(32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
        wait_result("b2b_first", 3'b100, 1, 2, 3);
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1;
        num1 = 32'h0000_0010; num2 = 32'h0000_0010; signed_mode = 1'b0;
        #1;
        chk("b2b_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b0; in_valid = 1'b0; num1 = $urandom; num2 = $urandom;
        @(negedge clk);
        chk("b2b_scan_out_valid", out_valid, 0);
        chk("b2b_scan_in_ready", in_ready, 0);
        t = 1;
        while (!out_valid && t < 100) begin @(negedge clk); t++; end
        chk("b2b_second_gel", {g, e, l}, 3'b010);
        chk("b2b_second_ncyc", ncyc, 4);
        chk("b2b_second_latency", t, 5);
        release_out();

        // Asynchronous reset in the middle of a scan
        send(32'h1234_5600, 32'h1234_5601, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_gel", {g, e, l}, 3'b000);
        chk("midrst_in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("postrst_out_valid", out_valid, 0);
        send(32'd5, 32'd9, 1'b0);
        wait_result("postrst", 3'b001, 4, 5, 0);
        release_out();

        for (int i = 0; i < 3000; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = a ^ (32'h1 << $urandom_range(0, 31));
                default: b = $urandom;
            endcase
            sm = 1'($urandom);
            ref_cmp({32'h0, a}, {32'h0, b}, 32, 8, sm, eg, en);
            send(a, b, sm);
            wait_result($sformatf("rnd a=%h b=%h s=%0d", a, b, sm), eg, en, 1 + en,
                        $urandom_range(0, 2));
            release_out();
        end

        t = 0;
        while (!(g_sub[0].done && g_sub[1].done) && t < 60000) begin @(negedge clk); t++; end
        chk("sub_benches_done", {g_sub[0].done, g_sub[1].done}, 2'b11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
